// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = a - b - bin, one bit per cycle, LSB first.
// A single borrow flop replaces the carry chain; start/done handshake with busy while running.
//
// Handshake: start is a request sampled only on an edge where the unit is not busy
// (IDLE or DONE); done is a one-cycle pulse marking d/bout/zero/ovf as valid, and
// those outputs hold until the next completion. busy stays high for exactly WIDTH cycles.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             ai, bi, di, br_nxt;
    logic [WIDTH-1:0] r_nxt;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        // One full-subtractor slice on the current LSBs of the operand shift registers
        ai     = a_sh_q[0];
        bi     = b_sh_q[0];
        di     = ai ^ bi ^ br_q;
        br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);
        r_nxt  = {di, r_sh_q[WIDTH-1:1]};

        case (state_q)
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_sh_d = r_nxt;
                br_d   = br_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // All result flags publish on the same edge so they are never seen half-updated
                    state_d = S_DONE;
                    d_d     = r_nxt;
                    bout_d  = br_nxt;
                    zero_d  = (r_nxt == '0);
                    ovf_d   = (a_msb_q != b_msb_q) && (di != a_msb_q);
                end
            end
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    r_sh_d  = '0;
                    br_d    = bin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign d         = d_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, then randomized operands
// checked against an arithmetic reference model through an expected-result queue.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             busy, done, bout, zero, ovf;
    logic [WIDTH-1:0] d;
    logic [1:0]       dbg_state;

    int n_assert = 0;
    int n_fail = 0;
    int done_seen = 0;
    int ops_done = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [2:0]       flag_q[$];   // {bout, zero, ovf}

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .d         (d),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain (WIDTH+1)-bit arithmetic on the operands
    task automatic push_expected(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
        int               diff;
        logic [WIDTH-1:0] dv;
        logic             ov;
        diff = int'(av) - int'(bv) - int'(bi);
        dv   = WIDTH'(diff);
        ov   = (av[WIDTH-1] != bv[WIDTH-1]) && (dv[WIDTH-1] != av[WIDTH-1]);
        exp_q.push_back(dv);
        flag_q.push_back({diff < 0, dv == '0, ov});
    endtask

    task automatic check_result(input string tag);
        logic [WIDTH-1:0] ed;
        logic [2:0]       ef;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        ed = exp_q.pop_front();
        ef = flag_q.pop_front();
        ops_done++;
        check({tag, "_d"},    32'(d),    32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(ef[2]));
        check({tag, "_zero"}, 32'(zero), 32'(ef[1]));
        check({tag, "_ovf"},  32'(ovf),  32'(ef[0]));
    endtask

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge after the accepting edge (first busy cycle).
    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input logic bi, input bit push);
        a = av; b = bv; bin = bi; start = 1'b1;
        if (push) push_expected(av, bv, bi);
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done", 32'(done), 32'd0);
    endtask

    // lat counts negedges from the call (call point = 1) until done is seen; 0 on timeout
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 4 * WIDTH; i++) begin
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    int lat, bc, gap, pick;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-1:0] corner[4];

    initial begin
        corner[0] = '0;
        corner[1] = {1'b0, {(WIDTH-1){1'b1}}};
        corner[2] = {1'b1, {(WIDTH-1){1'b0}}};
        corner[3] = '1;

        do_reset();
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_d",     32'(d),         32'd0);
        check("rst_bout",  32'(bout),      32'd0);
        check("rst_zero",  32'(zero),      32'd0);
        check("rst_ovf",   32'(ovf),       32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Basic op: latency, busy length, result, single-cycle done
        start_op(8'd5, 8'd3, 1'b0, 1);
        wait_done(lat, bc);
        check("t1_latency", 32'(lat), 32'(WIDTH + 1));
        check("t1_busy_cycles", 32'(bc), 32'(WIDTH));
        check_result("t1");
        check("t1_d_const", 32'(d), 32'h02);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_d_hold", 32'(d), 32'h02);

        // Directed borrow / overflow / zero cases
        start_op(8'd3, 8'd5, 1'b0, 1);    wait_done(lat, bc); check_result("t2a");
        check("t2a_d_const", 32'(d), 32'hFE);
        start_op(8'd0, 8'd0, 1'b1, 1);    wait_done(lat, bc); check_result("t2b");
        check("t2b_d_const", 32'(d), 32'hFF);
        start_op(8'h80, 8'h01, 1'b0, 1);  wait_done(lat, bc); check_result("t3a");
        check("t3a_ovf_const", 32'(ovf), 32'd1);
        start_op(8'd7, 8'd7, 1'b0, 1);    wait_done(lat, bc); check_result("t3b");
        check("t3b_zero_const", 32'(zero), 32'd1);
        @(negedge clk);

        // Start pulse with new operands mid-RUN is ignored
        start_op(8'd5, 8'd3, 1'b0, 1);
        repeat (2) @(negedge clk);
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("t4_latency", 32'(lat), 32'(WIDTH + 1 - 3));
        check_result("t4");
        @(negedge clk);
        check("t4_no_extra_op", 32'(busy), 32'd0);

        // Start held high from mid-RUN through DONE: back-to-back op
        start_op(8'd20, 8'd7, 1'b0, 1);
        repeat (3) @(negedge clk);
        a = 8'd9; b = 8'd4; bin = 1'b0; start = 1'b1;
        push_expected(8'd9, 8'd4, 1'b0);
        wait_done(lat, bc);
        check("t5_first_latency", 32'(lat), 32'(WIDTH + 1 - 3));
        check_result("t5a");
        @(negedge clk);
        start = 1'b0;
        check("t5_b2b_busy", 32'(busy), 32'd1);
        check("t5_b2b_done", 32'(done), 32'd0);
        wait_done(lat, bc);
        check("t5_second_latency", 32'(lat), 32'(WIDTH + 1));
        check_result("t5b");
        check("t5b_d_const", 32'(d), 32'h05);
        @(negedge clk);

        // Reset in the fourth RUN cycle aborts with no done pulse
        start_op(8'd100, 8'd33, 1'b1, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_d",    32'(d),    32'd0);
        check("t6_bout", 32'(bout), 32'd0);
        bc = 0;
        repeat (2 * WIDTH) begin
            @(negedge clk);
            if (done === 1'b1) bc++;
        end
        check("t6_no_done", 32'(bc), 32'd0);
        start_op(8'd100, 8'd33, 1'b1, 1);
        wait_done(lat, bc);
        check("t6_fresh_latency", 32'(lat), 32'(WIDTH + 1));
        check_result("t6_fresh");

        // Randomized operands, mixed with corner values and random idle gaps
        repeat (30) begin
            pick = $urandom_range(0, 5);
            ra = (pick < 4) ? corner[pick] : WIDTH'($urandom);
            pick = $urandom_range(0, 5);
            rb = (pick < 4) ? corner[pick] : WIDTH'($urandom);
            start_op(ra, rb, 1'($urandom_range(0, 1)), 1);
            wait_done(lat, bc);
            check("rnd_latency", 32'(lat), 32'(WIDTH + 1));
            check("rnd_busy_cycles", 32'(bc), 32'(WIDTH));
            check_result("rnd");
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                ra = d;
                @(negedge clk);
                check("rnd_done_pulse", 32'(done), 32'd0);
                check("rnd_d_hold", 32'(d), 32'(ra));
                repeat (gap - 1) @(negedge clk);
            end
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        check("done_pulse_count", 32'(done_seen), 32'(ops_done));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
